// File: rtl/digital_lock_fsm.sv
// Keypad combination lock: collects digit pulses, checks them on ENTER, drives unlocked/alarm with timed relock and lockout.
// Latency: every output is registered; unlocked/alarm change on the first edge after the ENTER cycle.
// Backpressure: none; input pulses are taken as they come and are dropped while UNLOCKED (digits) or LOCKOUT (all keys).
module digital_lock_fsm #(
    parameter int unsigned CODE_LEN       = 4,
    parameter logic [15:0] CODE           = 16'b10_00_11_01,
    parameter int unsigned MAX_FAIL       = 3,
    parameter int unsigned UNLOCK_CYCLES  = 500,
    parameter int unsigned LOCKOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sw1,
    input  logic       sw2,
    input  logic       sw3,
    input  logic       sw4,
    input  logic       sw5,
    output logic       unlocked,
    output logic       alarm,
    output logic [3:0] digit_count,
    output logic [2:0] fail_count,
    output logic [1:0] state
);

    // One timer serves both timed states; its largest value is one less than the longer period.
    localparam int unsigned TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int unsigned TW   = (TMAX < 2) ? 1 : $clog2(TMAX);

    localparam logic [TW-1:0]         UNLOCK_LAST  = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0]         LOCKOUT_LAST = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [3:0]            CNT_FULL     = 4'(CODE_LEN);
    localparam logic [2:0]            FAIL_LIMIT   = 3'(MAX_FAIL);
    localparam logic [2*CODE_LEN-1:0] CODE_SEQ     = CODE[2*CODE_LEN-1:0];

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_UNLOCKED = 2'b01,
        ST_LOCKOUT  = 2'b10
    } state_e;

    state_e                 state_q;
    logic                   unlocked_q;
    logic                   alarm_q;
    logic [3:0]             cnt_q;
    logic [2:0]             fail_q;
    logic [2*CODE_LEN-1:0]  buf_q;
    logic                   ovf_q;
    logic                   inv_q;
    logic [TW-1:0]          tmr_q;

    logic [3:0]             keys_d;
    logic                   one_key_d;
    logic                   multi_key_d;
    logic [1:0]             digit_d;
    logic                   match_d;
    logic [2:0]             fail_inc_d;

    // Key decode: a single digit key is a usable press, more than one at once poisons the entry.
    assign keys_d      = {sw4, sw3, sw2, sw1};
    assign one_key_d   = $onehot(keys_d);
    assign multi_key_d = (keys_d != 4'd0) && !one_key_d;
    assign digit_d     = sw4 ? 2'd3 : (sw3 ? 2'd2 : (sw2 ? 2'd1 : 2'd0));

    // An entry matches only when it is exactly full, clean, and equal to the code.
    assign match_d     = (cnt_q == CNT_FULL) && (buf_q == CODE_SEQ) && !ovf_q && !inv_q;
    assign fail_inc_d  = fail_q + 3'd1;

    // Lock controller: state, entry buffer, fail counter, timer and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            unlocked_q <= 1'b0;
            alarm_q    <= 1'b0;
            cnt_q      <= 4'd0;
            fail_q     <= 3'd0;
            buf_q      <= '0;
            ovf_q      <= 1'b0;
            inv_q      <= 1'b0;
            tmr_q      <= '0;
        end else begin
            case (state_q)
                ST_UNLOCKED: begin
                    // ENTER relocks early; otherwise relock when the open window runs out.
                    if (sw5 || (tmr_q == UNLOCK_LAST)) begin
                        state_q    <= ST_IDLE;
                        unlocked_q <= 1'b0;
                        tmr_q      <= '0;
                    end else begin
                        tmr_q      <= tmr_q + 1'b1;
                    end
                end

                ST_LOCKOUT: begin
                    // Every key is ignored until the penalty period has elapsed.
                    if (tmr_q == LOCKOUT_LAST) begin
                        state_q <= ST_IDLE;
                        alarm_q <= 1'b0;
                        fail_q  <= 3'd0;
                        tmr_q   <= '0;
                    end else begin
                        tmr_q   <= tmr_q + 1'b1;
                    end
                end

                default: begin
                    // IDLE, and the unused encoding which behaves as IDLE.
                    state_q <= ST_IDLE;
                    if (sw5) begin
                        // ENTER wins over any digit in the same cycle; the entry is consumed either way.
                        cnt_q <= 4'd0;
                        buf_q <= '0;
                        ovf_q <= 1'b0;
                        inv_q <= 1'b0;
                        if (match_d) begin
                            state_q    <= ST_UNLOCKED;
                            unlocked_q <= 1'b1;
                            fail_q     <= 3'd0;
                            tmr_q      <= '0;
                        end else begin
                            fail_q <= fail_inc_d;
                            if (fail_inc_d == FAIL_LIMIT) begin
                                state_q <= ST_LOCKOUT;
                                alarm_q <= 1'b1;
                                tmr_q   <= '0;
                            end
                        end
                    end else if (one_key_d) begin
                        if (cnt_q == CNT_FULL) begin
                            ovf_q <= 1'b1;
                        end else begin
                            buf_q[{cnt_q, 1'b0} +: 2] <= digit_d;
                            cnt_q                     <= cnt_q + 4'd1;
                        end
                    end else if (multi_key_d) begin
                        inv_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign unlocked    = unlocked_q;
    assign alarm       = alarm_q;
    assign digit_count = cnt_q;
    assign fail_count  = fail_q;
    assign state       = state_q;

endmodule
